cpu_port_sram: RTL and testbench

Single-ported, word-organised SRAM responder that implements the slave side of the CPU request/response port used by `cache_top`. It accepts one request at a time and returns a one-cycle response after a fixed, parameterised latency. It stands in for the cache as a drop-in target for CPU-side masters, and gives the CPU port protocol a reference responder for bring-up and for protocol checks.

---
 rtl/cpu_port_sram.sv | 128 ++++++++++++
 tb/tb_cpu_port_sram.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_port_sram.sv
// Word-organised single-port SRAM answering the CPU request/response port.
// One request in flight; response pulse after a fixed LATENCY.
module cpu_port_sram #(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 4,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_req_rw,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic                cpu_resp_valid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_resp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-3:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     wstrb;
  } req_t;

  state_t            state;
  state_t            state_nx;
  req_t              req;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             commit;
  logic             oor;
  logic [IDX_W-1:0] idx;

  assign accept = cpu_req_valid & cpu_req_ready;
  assign commit = (state == BUSY) && (cnt == 8'd0);
  assign idx    = req.addr[IDX_W-1:0];
  assign oor    = |req.addr[ADDR_W-3:IDX_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cpu_req_valid) state_nx = BUSY;
      BUSY:    if (cnt == 8'd0)   state_nx = RESP;
      RESP:    state_nx = cpu_req_valid ? BUSY : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cpu_req_ready  = (state != BUSY);
    cpu_resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req <= '0;
      cnt <= 8'd0;
    end else if (accept) begin
      req.rw    <= cpu_req_rw;
      req.addr  <= cpu_addr[ADDR_W-1:2];
      req.wdata <= cpu_wdata;
      req.wstrb <= cpu_wstrb;
      cnt       <= 8'(LATENCY - 1);
    end else if (state == BUSY && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata    <= '0;
      cpu_resp_err <= 1'b0;
    end else if (commit) begin
      unique case (1'b1)
        (!req.rw && !oor): begin
          cpu_rdata    <= mem[idx];
          cpu_resp_err <= 1'b0;
        end
        (!req.rw && oor): begin
          cpu_rdata    <= ERR_DATA;
          cpu_resp_err <= 1'b1;
        end
        (req.rw && !oor): begin
          cpu_rdata    <= '0;
          cpu_resp_err <= 1'b0;
        end
        default: begin
          cpu_rdata    <= '0;
          cpu_resp_err <= 1'b1;
        end
      endcase
    end else if (state == RESP) begin
      cpu_rdata    <= '0;
      cpu_resp_err <= 1'b0;
    end
  end

  // Array has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (commit && req.rw && !oor) begin
      for (int i = 0; i < NB; i++) begin
        if (req.wstrb[i]) mem[idx][8*i +: 8] <= req.wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cpu_port_sram.sv
// Directed bench for cpu_port_sram with LATENCY=4, DEPTH_WORDS=1024.
module tb_cpu_port_sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_rw;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_resp_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_resp_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_port_sram dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_rw     (cpu_req_rw),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_wstrb      (cpu_wstrb),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_rdata      (cpu_rdata),
    .cpu_resp_err   (cpu_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload_word(input int i, input logic [31:0] d);
    @(negedge clk);
    dut.mem[i] <= d;
    @(negedge clk);
  endtask

  task automatic peek_word(input int i, output logic [31:0] d);
    d = dut.mem[i];
  endtask

  // Issue one request from IDLE and wait for its response.
  // Returns at the negedge after the response cycle.
  task automatic run_req(input logic rw, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st,
                         output logic [31:0] rd, output logic er,
                         output int lat, output int busy_low);
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = rw;
    cpu_addr      = a;
    cpu_wdata     = wd;
    cpu_wstrb     = st;
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    lat      = 0;
    busy_low = 0;
    while (!cpu_resp_valid && lat < 20) begin
      if (!cpu_req_ready) busy_low++;
      @(negedge clk);
      lat++;
    end
    rd = cpu_rdata;
    er = cpu_resp_err;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic [31:0] w;
  logic        er;
  int          lat;
  int          bl;
  int          nresp;

  initial begin
    rst_n         = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_rw    = 1'b0;
    cpu_addr      = '0;
    cpu_wdata     = '0;
    cpu_wstrb     = '0;
    #12;
    chk("rst_ready", 32'(cpu_req_ready), 32'd1);
    chk("rst_valid", 32'(cpu_resp_valid), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_err", 32'(cpu_resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cpu_req_ready), 32'd1);

    // Basic read latency
    preload_word(32'h11, 32'h1111_0000);
    run_req(1'b0, 32'h44, '0, 4'h0, rd, er, lat, bl);
    chk("rd_data", rd, 32'h1111_0000);
    chk("rd_err", 32'(er), 32'd0);
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_busy_cycles", 32'(bl), 32'd4);
    chk("rd_pulse_len", 32'(cpu_resp_valid), 32'd0);
    chk("rd_data_clear", cpu_rdata, 32'd0);

    // Byte-strobe merge
    run_req(1'b1, 32'h44, 32'h0000_00AA, 4'b0001, rd, er, lat, bl);
    chk("wr_rdata_zero", rd, 32'd0);
    chk("wr_err", 32'(er), 32'd0);
    run_req(1'b0, 32'h44, '0, 4'h0, rd, er, lat, bl);
    chk("merge_lane0", rd, 32'h1111_00AA);
    run_req(1'b1, 32'h44, 32'hBB00_0000, 4'b1000, rd, er, lat, bl);
    run_req(1'b0, 32'h44, '0, 4'h0, rd, er, lat, bl);
    chk("merge_lane3", rd, 32'hBB11_00AA);

    // Zero-strobe write leaves the word alone
    run_req(1'b1, 32'h44, 32'hFFFF_FFFF, 4'b0000, rd, er, lat, bl);
    chk("wstrb0_err", 32'(er), 32'd0);
    peek_word(32'h11, w);
    chk("wstrb0_word", w, 32'hBB11_00AA);

    // Back-to-back write then read
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = 1'b1;
    cpu_addr      = 32'h80;
    cpu_wdata     = 32'hCAFE_F00D;
    cpu_wstrb     = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cpu_req_rw = 1'b0;
    lat = 0;
    while (!cpu_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first_lat", 32'(lat), 32'd4);
    chk("b2b_resp_ready", 32'(cpu_req_ready), 32'd1);
    @(negedge clk);
    chk("b2b_second_acc", 32'(cpu_req_ready), 32'd0);
    chk("b2b_valid_drop", 32'(cpu_resp_valid), 32'd0);
    cpu_req_valid = 1'b0;
    lat = 1;
    while (!cpu_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_gap", 32'(lat), 32'd5);
    chk("b2b_rdata", cpu_rdata, 32'hCAFE_F00D);
    @(negedge clk);

    // Out of range
    preload_word(0, 32'hA5A5_0000);
    run_req(1'b0, 32'h1000, '0, 4'h0, rd, er, lat, bl);
    chk("oor_rd_err", 32'(er), 32'd1);
    chk("oor_rd_data", rd, 32'hDEAD_BEEF);
    run_req(1'b1, 32'h1000, 32'h1234_4321, 4'hF, rd, er, lat, bl);
    chk("oor_wr_err", 32'(er), 32'd1);
    chk("oor_wr_data", rd, 32'd0);
    peek_word(0, w);
    chk("oor_wr_word0", w, 32'hA5A5_0000);

    // Request ignored while busy
    preload_word(32'h10, 32'h0BAD_0010);
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = 1'b0;
    cpu_addr      = 32'h44;
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = 1'b1;
    cpu_addr      = 32'h40;
    cpu_wdata     = 32'hFFFF_FFFF;
    cpu_wstrb     = 4'hF;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    nresp = 0;
    for (int i = 0; i < 15; i++) begin
      if (cpu_resp_valid) nresp++;
      @(negedge clk);
    end
    chk("busy_ignore_resps", 32'(nresp), 32'd1);
    peek_word(32'h10, w);
    chk("busy_ignore_word", w, 32'h0BAD_0010);

    // Reset mid-flight
    preload_word(32'h10, 32'h1234_5678);
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = 1'b1;
    cpu_addr      = 32'h40;
    cpu_wdata     = 32'h5555_5555;
    cpu_wstrb     = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(cpu_req_ready), 32'd1);
    chk("mid_rst_valid", 32'(cpu_resp_valid), 32'd0);
    chk("mid_rst_rdata", cpu_rdata, 32'd0);
    chk("mid_rst_err", 32'(cpu_resp_err), 32'd0);
    nresp = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (cpu_resp_valid) nresp++;
      @(negedge clk);
    end
    chk("mid_rst_no_resp", 32'(nresp), 32'd0);
    peek_word(32'h10, w);
    chk("mid_rst_word", w, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
